// File: rtl/pong_text_pkg.sv
// pong_text_pkg: shared constants for the Pong score-line text generator.
//   - character codes used by the string "Score:DD Ball:D"
//   - text geometry (glyph row bits, number of text columns)
//   - text_char(): column -> character code for the score line
package pong_text_pkg;

  localparam logic [6:0] CH_S      = 7'h53;
  localparam logic [6:0] CH_C      = 7'h63;
  localparam logic [6:0] CH_O      = 7'h6f;
  localparam logic [6:0] CH_R      = 7'h72;
  localparam logic [6:0] CH_E      = 7'h65;
  localparam logic [6:0] CH_COLON  = 7'h3a;
  localparam logic [6:0] CH_B      = 7'h42;
  localparam logic [6:0] CH_A      = 7'h61;
  localparam logic [6:0] CH_L      = 7'h6c;
  localparam logic [6:0] CH_DIGIT0 = 7'h30;
  localparam logic [6:0] CH_BLANK  = 7'h00;

  localparam int TEXT_ROW_BITS = 4;
  localparam int TEXT_COLS     = 15;

  // Character code for a text column, given the displayed digits.
  function automatic logic [6:0] text_char(input logic [3:0] col,
                                           input logic [3:0] tens,
                                           input logic [3:0] units,
                                           input logic [3:0] balls);
    logic [6:0] code;
    case (col)
      4'd0:    code = CH_S;
      4'd1:    code = CH_C;
      4'd2:    code = CH_O;
      4'd3:    code = CH_R;
      4'd4:    code = CH_E;
      4'd5:    code = CH_COLON;
      4'd6:    code = CH_DIGIT0 + {3'b000, tens};
      4'd7:    code = CH_DIGIT0 + {3'b000, units};
      4'd8:    code = CH_BLANK;
      4'd9:    code = CH_B;
      4'd10:   code = CH_A;
      4'd11:   code = CH_L;
      4'd12:   code = CH_L;
      4'd13:   code = CH_COLON;
      4'd14:   code = CH_DIGIT0 + {3'b000, balls};
      default: code = CH_BLANK;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/pong_text_gen_if.sv
// pong_text_if: pixel/ROM/text-pixel bundle between the video path and the
// text generator.
//   master: drives pixel position, video_on and the ROM glyph row;
//           receives rom_addr and the text pixel flag/colour.
//   slave : the text generator.
interface pong_text_if;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;
  logic        text_on;
  logic [2:0]  text_rgb;

  modport master (
    output pixel_x, pixel_y, video_on, rom_data,
    input  rom_addr, text_on, text_rgb
  );

  modport slave (
    input  pixel_x, pixel_y, video_on, rom_data,
    output rom_addr, text_on, text_rgb
  );
endinterface

// File: rtl/pong_score_counter.sv
// pong_score_counter: two-digit BCD score counter, 00..99, wraps 99 -> 00.
//   clk, rst : clock, asynchronous active-high reset (score := 00)
//   inc      : pulse, add one
//   clr      : pulse, score := 00 (wins over inc)
//   tens     : BCD tens digit
//   units    : BCD units digit
module pong_score_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] units
);

  // BCD count with decimal carry from units into tens.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (clr) begin
      tens  <= 4'd0;
      units <= 4'd0;
    end else if (inc) begin
      if (units == 4'd9) begin
        units <= 4'd0;
        tens  <= (tens == 4'd9) ? 4'd0 : tens + 4'd1;
      end else begin
        units <= units + 4'd1;
      end
    end
  end

endmodule

// File: rtl/pong_text_gen.sv
// pong_text_gen: score-line text generator for the Pong display.
//   clk, reset : pixel clock, asynchronous active-high reset
//   score_inc  : pulse, score + 1 (BCD, wraps at 99)
//   score_clr  : pulse, score := 00 (wins over score_inc)
//   ball_dec   : pulse, balls - 1 saturating at 0
//   ball_load  : pulse, balls := BALLS_INIT (wins over ball_dec)
//   bus        : pixel position / video_on in, rom_addr out (combinational),
//                rom_data in (one cycle after rom_addr), text_on/text_rgb out
//                one cycle after the pixel position.
module pong_text_gen
  import pong_text_pkg::*;
#(
  parameter logic [2:0] TEXT_RGB   = 3'b110,
  parameter logic [3:0] BALLS_INIT = 4'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        score_inc,
  input  logic        score_clr,
  input  logic        ball_dec,
  input  logic        ball_load,
  pong_text_if.slave  bus
);

  localparam logic [3:0] LAST_COL = 4'(TEXT_COLS - 1);

  logic [3:0] tens_s;
  logic [3:0] units_s;
  logic [3:0] balls_r;
  logic [3:0] disp_tens_r;
  logic [3:0] disp_units_r;
  logic [3:0] disp_balls_r;
  logic       region_d;
  logic [2:0] bit_sel_d;

  logic [3:0] col_s;
  logic       region_s;
  logic       frame_origin_s;
  logic [6:0] char_code_s;
  logic       font_bit_s;

  pong_score_counter u_score (
    .clk   (clk),
    .rst   (reset),
    .inc   (score_inc),
    .clr   (score_clr),
    .tens  (tens_s),
    .units (units_s)
  );

  assign col_s          = bus.pixel_x[7:4];
  assign frame_origin_s = (bus.pixel_x == 10'd0) && (bus.pixel_y == 10'd0);
  // 16x32 cells: top 32 rows, first 15 of the 16 columns below x=256.
  assign region_s = (bus.pixel_y[9:5] == 5'd0) && (bus.pixel_x[9:8] == 2'd0) &&
                    (col_s <= LAST_COL) && bus.video_on;

  // Character selection; only snapshot values feed the glyphs.
  always_comb begin
    char_code_s = CH_BLANK;
    if (region_s) begin
      char_code_s = text_char(col_s, disp_tens_r, disp_units_r, disp_balls_r);
    end else begin
      char_code_s = CH_BLANK;
    end
  end

  assign bus.rom_addr = {char_code_s, bus.pixel_y[TEXT_ROW_BITS:1]};

  // Ball counter: load wins over decrement, decrement saturates at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      balls_r <= BALLS_INIT;
    end else if (ball_load) begin
      balls_r <= BALLS_INIT;
    end else if (ball_dec && (balls_r != 4'd0)) begin
      balls_r <= balls_r - 4'd1;
    end
  end

  // Once-per-frame snapshot so digits never change mid-frame; a counter
  // update in the origin cycle is picked up one frame later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      disp_tens_r  <= 4'd0;
      disp_units_r <= 4'd0;
      disp_balls_r <= BALLS_INIT;
    end else if (frame_origin_s) begin
      disp_tens_r  <= tens_s;
      disp_units_r <= units_s;
      disp_balls_r <= balls_r;
    end
  end

  // Delay region flag and bit select to line up with the registered ROM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      region_d  <= 1'b0;
      bit_sel_d <= 3'd0;
    end else begin
      region_d  <= region_s;
      bit_sel_d <= bus.pixel_x[3:1];
    end
  end

  assign font_bit_s   = bus.rom_data[3'd7 - bit_sel_d];
  assign bus.text_on  = region_d & font_bit_s;
  assign bus.text_rgb = bus.text_on ? TEXT_RGB : 3'b000;

endmodule

// File: tb/tb_pong_text_gen.sv
// tb_pong_text_gen: randomized and directed self-checking bench for
// pong_text_gen. The reference model builds the score line as a text string
// and computes region/glyph geometry with plain arithmetic.
module tb_pong_text_gen;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic score_inc = 1'b0, score_clr = 1'b0, ball_dec = 1'b0, ball_load = 1'b0;

  pong_text_if bus ();

  pong_text_gen dut (
    .clk       (clk),
    .reset     (reset),
    .score_inc (score_inc),
    .score_clr (score_clr),
    .ball_dec  (ball_dec),
    .ball_load (ball_load),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int m_score, m_balls, d_score, d_balls;
  bit pend_region;
  int pend_bitsel;

  function automatic bit ref_region(int x, int y, bit v);
    return v && (y < 32) && (x < 240);
  endfunction

  function automatic logic [10:0] ref_addr(int x, int y, bit v);
    logic [6:0] c;
    string s;
    byte b;
    c = 7'h00;
    if (ref_region(x, y, v)) begin
      s = $sformatf("Score:%0d%0d Ball:%0d", d_score / 10, d_score % 10, d_balls);
      b = s[x / 16];
      c = (b == " ") ? 7'h00 : b[6:0];
    end
    return {c, 4'((y / 2) % 16)};
  endfunction

  // One pixel clock: drive inputs after the falling edge, predict outputs.
  task automatic cycle(input int x, input int y, input bit v, input logic [7:0] rd,
                       input bit inc, input bit clr, input bit dec, input bit ld,
                       output logic [10:0] ea, output logic eon);
    @(negedge clk);
    bus.pixel_x  = 10'(x);
    bus.pixel_y  = 10'(y);
    bus.video_on = v;
    bus.rom_data = rd;
    score_inc = inc; score_clr = clr; ball_dec = dec; ball_load = ld;
    eon = pend_region && rd[7 - pend_bitsel];
    ea  = ref_addr(x, y, v);
    pend_region = ref_region(x, y, v);
    pend_bitsel = (x / 2) % 8;
    if (x == 0 && y == 0) begin
      d_score = m_score;
      d_balls = m_balls;
    end
    if (clr) m_score = 0;
    else if (inc) m_score = (m_score + 1) % 100;
    if (ld) m_balls = 3;
    else if (dec && m_balls > 0) m_balls = m_balls - 1;
    #1;
  endtask

  task automatic do_reset();
    score_inc = 1'b0; score_clr = 1'b0; ball_dec = 1'b0; ball_load = 1'b0;
    reset = 1'b1;
    m_score = 0; m_balls = 3; d_score = 0; d_balls = 3;
    pend_region = 1'b0; pend_bitsel = 0;
    #1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    bus.video_on = 1'b0;
    bus.pixel_x  = 10'd500;
    bus.pixel_y  = 10'd100;
    reset = 1'b0;
    pend_region = 1'b0;
  endtask

  task automatic test_reset();
    logic [10:0] ea; logic eon;
    do_reset();
    n_cmp++; if (bus.text_on !== 1'b0) begin n_bad++; $display("FAIL reset_on got %b want 0", bus.text_on); end
    n_cmp++; if (bus.text_rgb !== 3'b000) begin n_bad++; $display("FAIL reset_rgb got %b want 000", bus.text_rgb); end
    release_reset();
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h530) begin n_bad++; $display("FAIL origin_addr got %h want 530", bus.rom_addr); end
    cycle(8, 0, 1, 8'hFF, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== ea) begin n_bad++; $display("FAIL addr_8_0 got %h want %h", bus.rom_addr, ea); end
    n_cmp++; if (bus.text_on !== eon) begin n_bad++; $display("FAIL on_0_0 got %b want %b", bus.text_on, eon); end
    cycle(500, 0, 0, 8'hFF, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.text_on !== 1'b1 || eon !== 1'b1) begin n_bad++; $display("FAIL on_8_0 got %b want 1", bus.text_on); end
    n_cmp++; if (bus.text_rgb !== 3'b110) begin n_bad++; $display("FAIL rgb_8_0 got %b want 110", bus.text_rgb); end
  endtask

  task automatic test_digit();
    logic [10:0] ea; logic eon;
    cycle(96, 2, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== {7'h30, 4'd1}) begin n_bad++; $display("FAIL tens_addr got %h want %h", bus.rom_addr, {7'h30, 4'd1}); end
    cycle(97, 2, 1, 8'h80, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.text_on !== 1'b1) begin n_bad++; $display("FAIL on_x96 got %b want 1", bus.text_on); end
    cycle(98, 2, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(99, 2, 1, 8'h80, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.text_on !== 1'b0) begin n_bad++; $display("FAIL on_x98 got %b want 0", bus.text_on); end
  endtask

  task automatic test_score_wrap();
    logic [10:0] ea; logic eon;
    for (int i = 0; i < 100; i++) cycle(300, 100, 0, 8'h00, 1, 0, 0, 0, ea, eon);
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(96, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h300 || ea !== 11'h300) begin n_bad++; $display("FAIL wrap_tens got %h want 300", bus.rom_addr); end
    for (int i = 0; i < 23; i++) cycle(300, 100, 0, 8'h00, 1, 0, 0, 0, ea, eon);
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(96, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h320) begin n_bad++; $display("FAIL s23_tens got %h want 320", bus.rom_addr); end
    cycle(112, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h330) begin n_bad++; $display("FAIL s23_units got %h want 330", bus.rom_addr); end
  endtask

  task automatic test_priority();
    logic [10:0] ea; logic eon;
    cycle(300, 100, 0, 8'h00, 1, 1, 0, 0, ea, eon);
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(112, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h300) begin n_bad++; $display("FAIL clr_prio got %h want 300", bus.rom_addr); end
    for (int i = 0; i < 4; i++) cycle(300, 100, 0, 8'h00, 0, 0, 1, 0, ea, eon);
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(224, 6, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== {7'h30, 4'd3}) begin n_bad++; $display("FAIL balls_sat got %h want %h", bus.rom_addr, {7'h30, 4'd3}); end
    cycle(300, 100, 0, 8'h00, 0, 0, 1, 1, ea, eon);
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(224, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h330) begin n_bad++; $display("FAIL load_prio got %h want 330", bus.rom_addr); end
  endtask

  task automatic test_snapshot();
    logic [10:0] ea; logic eon;
    cycle(300, 100, 0, 8'h00, 1, 0, 0, 0, ea, eon);
    cycle(112, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h300) begin n_bad++; $display("FAIL no_tear got %h want 300", bus.rom_addr); end
    cycle(0, 0, 1, 8'h00, 1, 0, 0, 0, ea, eon);
    cycle(112, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h310) begin n_bad++; $display("FAIL snap1 got %h want 310", bus.rom_addr); end
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(112, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h320) begin n_bad++; $display("FAIL snap2 got %h want 320", bus.rom_addr); end
  endtask

  task automatic test_col15();
    logic [10:0] ea; logic eon;
    cycle(240, 4, 1, 8'hFF, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== {7'h00, 4'd2}) begin n_bad++; $display("FAIL col15_addr got %h want %h", bus.rom_addr, {7'h00, 4'd2}); end
    cycle(256, 4, 1, 8'hFF, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.text_on !== 1'b0) begin n_bad++; $display("FAIL col15_on got %b want 0", bus.text_on); end
    cycle(300, 4, 1, 8'hFF, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.text_on !== 1'b0) begin n_bad++; $display("FAIL x256_on got %b want 0", bus.text_on); end
  endtask

  task automatic test_random();
    logic [10:0] ea; logic eon;
    int x, y;
    for (int i = 0; i < 600; i++) begin
      x = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(0, 319));
      y = (x == 0 && $urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 47));
      cycle(x, y, ($urandom_range(0, 7) != 0), 8'($urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 40) == 0),
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 30) == 0), ea, eon);
      n_cmp++; if (bus.rom_addr !== ea) begin n_bad++; $display("FAIL rnd_addr[%0d] got %h want %h", i, bus.rom_addr, ea); end
      n_cmp++; if (bus.text_on !== eon) begin n_bad++; $display("FAIL rnd_on[%0d] got %b want %b", i, bus.text_on, eon); end
      n_cmp++; if (bus.text_rgb !== (eon ? 3'b110 : 3'b000)) begin n_bad++; $display("FAIL rnd_rgb[%0d] got %b", i, bus.text_rgb); end
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] ea; logic eon;
    for (int i = 0; i < 5; i++) cycle(300, 100, 0, 8'h00, 1, 0, 0, 1, ea, eon);
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(16, 4, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(500, 4, 0, 8'hFF, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.text_on !== 1'b1) begin n_bad++; $display("FAIL pre_reset_on got %b want 1", bus.text_on); end
    do_reset();
    n_cmp++; if (bus.text_on !== 1'b0) begin n_bad++; $display("FAIL mid_reset_on got %b want 0", bus.text_on); end
    release_reset();
    cycle(0, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    cycle(96, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h300) begin n_bad++; $display("FAIL rst_tens got %h want 300", bus.rom_addr); end
    cycle(112, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h300) begin n_bad++; $display("FAIL rst_units got %h want 300", bus.rom_addr); end
    cycle(224, 0, 1, 8'h00, 0, 0, 0, 0, ea, eon);
    n_cmp++; if (bus.rom_addr !== 11'h330) begin n_bad++; $display("FAIL rst_balls got %h want 330", bus.rom_addr); end
  endtask

  initial begin
    bus.pixel_x  = 10'd500;
    bus.pixel_y  = 10'd100;
    bus.video_on = 1'b0;
    bus.rom_data = 8'h00;
    test_reset();
    test_digit();
    test_score_wrap();
    test_priority();
    test_snapshot();
    test_col15();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
